curve_resampler: RTL and testbench

CURVE_RESAMPLER -- requirements
Module: curve_resampler

---
 rtl/resampler_pkg.sv | 20 ++
 rtl/seg_sqdist.sv | 33 +++
 rtl/curve_resampler.sv | 201 ++++++++++++++++++++
 tb/tb_curve_resampler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resampler_pkg.sv
// resampler_pkg
//   Shared definitions for the curve resampler:
//   - state_e      : FSM state encoding (IDLE, LOAD, MEASURE, EMIT)
//   - calc_len_w() : width of the accumulated curve length
package resampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_EMIT    = 2'd3
    } state_e;

    // One squared segment needs 2*coord_w+1 bits. Summing up to max_pts-1
    // of them adds clog2(max_pts) bits of headroom.
    function automatic int calc_len_w(input int coord_w, input int max_pts);
        return 2 * coord_w + 1 + $clog2(max_pts);
    endfunction

endpackage

// File: rtl/seg_sqdist.sv
// seg_sqdist
//   Combinational squared Euclidean distance between two points.
//   Ports:
//     a_x_i, a_y_i : first point
//     b_x_i, b_y_i : second point
//     dist_o       : dx^2 + dy^2 using absolute differences (2*COORD_W+1 bits)
module seg_sqdist #(
    parameter int COORD_W = 5
) (
    input  logic [COORD_W-1:0] a_x_i,
    input  logic [COORD_W-1:0] a_y_i,
    input  logic [COORD_W-1:0] b_x_i,
    input  logic [COORD_W-1:0] b_y_i,
    output logic [2*COORD_W:0] dist_o
);

    localparam int SQ_W = 2 * COORD_W;

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [SQ_W-1:0]    dx_sq;
    logic [SQ_W-1:0]    dy_sq;

    always_comb begin
        dx     = (a_x_i >= b_x_i) ? (a_x_i - b_x_i) : (b_x_i - a_x_i);
        dy     = (a_y_i >= b_y_i) ? (a_y_i - b_y_i) : (b_y_i - a_y_i);
        dx_sq  = SQ_W'(dx) * SQ_W'(dx);
        dy_sq  = SQ_W'(dy) * SQ_W'(dy);
        // Extra top bit keeps the sum of two full squares from overflowing.
        dist_o = {1'b0, dx_sq} + {1'b0, dy_sq};
    end

endmodule

// File: rtl/curve_resampler.sv
// curve_resampler
//   Buffers a polyline, measures its total (squared-segment) length, then
//   emits 2^OUT_LOG2 points spaced by an equal share of that length.
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1; valid, once raised, holds its payload until accepted.
//   Ports:
//     i_clk, i_rst_n        : clock, synchronous active-low reset
//     i_valid/i_x/i_y/i_last: input point stream, o_ready = can accept
//     o_valid/o_x/o_y       : resampled point, o_index its position,
//     o_index/o_last          o_last marks index N_OUT-1; i_ready accepts
//     o_total_length        : curve length, valid from EMIT until next LOAD
//     o_dbg_state           : current FSM state (resampler_pkg::state_e)
module curve_resampler
    import resampler_pkg::*;
#(
    parameter int  COORD_W  = 5,
    parameter int  MAX_PTS  = 64,
    parameter int  OUT_LOG2 = 4,
    localparam int LEN_W    = calc_len_w(COORD_W, MAX_PTS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [COORD_W-1:0]  i_x,
    input  logic [COORD_W-1:0]  i_y,
    input  logic                i_last,
    output logic                o_ready,
    output logic                o_valid,
    output logic [COORD_W-1:0]  o_x,
    output logic [COORD_W-1:0]  o_y,
    output logic [OUT_LOG2-1:0] o_index,
    output logic                o_last,
    input  logic                i_ready,
    output logic [LEN_W-1:0]    o_total_length,
    output logic [1:0]          o_dbg_state
);

    localparam int AW    = $clog2(MAX_PTS);
    localparam int CNT_W = AW + 1;
    localparam int PW    = 2 * COORD_W;
    localparam int DW    = 2 * COORD_W + 1;
    localparam logic [OUT_LOG2-1:0] LAST_IDX = {OUT_LOG2{1'b1}};

    state_e              state_q,   state_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic [AW-1:0]       seg_q,     seg_d;
    logic [LEN_W-1:0]    acc_q,     acc_d;
    logic [LEN_W-1:0]    len_q,     len_d;
    logic [LEN_W-1:0]    step_q,    step_d;
    logic [OUT_LOG2-1:0] out_idx_q, out_idx_d;
    logic                ovalid_q,  ovalid_d;

    logic [PW-1:0] mem_q [MAX_PTS];
    logic [PW-1:0] pt_a;
    logic [PW-1:0] pt_b;
    logic [AW-1:0] seg_next;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] seg_dist;
    logic          in_xfer;
    logic          advance;
    logic          go_emit;

    assign seg_next = seg_q + AW'(1);
    assign pt_a     = mem_q[seg_q];
    assign pt_b     = mem_q[seg_next];

    // One distance unit serves both the MEASURE sweep and the EMIT walk,
    // always on the segment (seg, seg+1).
    seg_sqdist #(.COORD_W(COORD_W)) u_sqdist (
        .a_x_i (pt_a[PW-1:COORD_W]),
        .a_y_i (pt_a[COORD_W-1:0]),
        .b_x_i (pt_b[PW-1:COORD_W]),
        .b_y_i (pt_b[COORD_W-1:0]),
        .dist_o(seg_dist)
    );

    assign o_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_LOAD) && (count_q != CNT_W'(MAX_PTS)));
    assign in_xfer = i_valid && o_ready;
    assign wr_addr = (state_q == ST_LOAD) ? count_q[AW-1:0] : '0;

    // The output point is always point seg; seg is frozen while o_valid is
    // high, so the payload is stable under backpressure.
    assign o_valid        = ovalid_q;
    assign o_x            = ovalid_q ? pt_a[PW-1:COORD_W] : '0;
    assign o_y            = ovalid_q ? pt_a[COORD_W-1:0]  : '0;
    assign o_index        = out_idx_q;
    assign o_last         = ovalid_q && (out_idx_q == LAST_IDX);
    assign o_total_length = len_q;
    assign o_dbg_state    = state_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        seg_d     = seg_q;
        acc_d     = acc_q;
        len_d     = len_q;
        step_d    = step_q;
        out_idx_d = out_idx_q;
        ovalid_d  = ovalid_q;
        advance   = 1'b0;
        go_emit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    count_d = CNT_W'(1);
                    len_d   = '0;
                    seg_d   = '0;
                    state_d = i_last ? ST_MEASURE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_xfer) begin
                    count_d = count_q + CNT_W'(1);
                    if (i_last || (count_d == CNT_W'(MAX_PTS))) begin
                        state_d = ST_MEASURE;
                    end
                end
            end
            ST_MEASURE: begin
                if (count_q <= CNT_W'(1)) begin
                    len_d   = '0;
                    go_emit = 1'b1;
                end else begin
                    len_d = len_q + LEN_W'(seg_dist);
                    seg_d = seg_next;
                    if ((CNT_W'(seg_q) + CNT_W'(2)) == count_q) begin
                        go_emit = 1'b1;
                    end
                end
                if (go_emit) begin
                    state_d   = ST_EMIT;
                    step_d    = len_d >> OUT_LOG2;
                    acc_d     = '0;
                    seg_d     = '0;
                    out_idx_d = '0;
                    ovalid_d  = 1'b1;
                end
            end
            ST_EMIT: begin
                if (!ovalid_q) begin
                    advance = 1'b1;
                end else if (i_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        state_d  = ST_IDLE;
                        ovalid_d = 1'b0;
                    end else begin
                        out_idx_d = out_idx_q + OUT_LOG2'(1);
                        advance   = 1'b1;
                    end
                end
                // Either emit the pending index at point seg (threshold
                // reached) or spend a silent cycle absorbing the next segment.
                if (advance) begin
                    if (step_q == '0) begin
                        ovalid_d = 1'b1;
                    end else if (acc_q >= step_q) begin
                        ovalid_d = 1'b1;
                        acc_d    = acc_q - step_q;
                    end else begin
                        ovalid_d = 1'b0;
                        seg_d    = seg_next;
                        acc_d    = acc_q + LEN_W'(seg_dist);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            seg_q     <= '0;
            acc_q     <= '0;
            len_q     <= '0;
            step_q    <= '0;
            out_idx_q <= '0;
            ovalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            seg_q     <= seg_d;
            acc_q     <= acc_d;
            len_q     <= len_d;
            step_q    <= step_d;
            out_idx_q <= out_idx_d;
            ovalid_q  <= ovalid_d;
        end
    end

    // Point storage needs no reset: a curve is always rewritten from
    // address 0 before it is read.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && in_xfer) begin
            mem_q[wr_addr] <= {i_x, i_y};
        end
    end

endmodule

// File: tb/tb_curve_resampler.sv
module tb_curve_resampler;

    localparam int W     = 15;   // {x[4:0], y[4:0], index[3:0], last}
    localparam int LEN_W = 17;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_x;
    logic [4:0] in_y;
    logic       in_last;
    logic       o_ready;
    logic       o_valid;
    logic [4:0] o_x;
    logic [4:0] o_y;
    logic [3:0] o_index;
    logic       o_last;
    logic       out_ready;
    logic [LEN_W-1:0] o_total_length;
    logic [1:0] o_dbg_state;

    int n_tests;
    int n_fail;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           held_bad;

    curve_resampler dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (in_valid),
        .i_x           (in_x),
        .i_y           (in_y),
        .i_last        (in_last),
        .o_ready       (o_ready),
        .o_valid       (o_valid),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_index       (o_index),
        .o_last        (o_last),
        .i_ready       (out_ready),
        .o_total_length(o_total_length),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic send_point(input logic [4:0] x, input logic [4:0] y, input logic last);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_last  = last;
        while (!o_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: o_ready=%b, required 1", o_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_line(input int n);
        for (int k = 0; k < n; k++) begin
            send_point(5'(k), 5'd0, (k == n - 1));
        end
    endtask

    // Collects up to n outputs into got_q; optionally holds i_ready low for
    // stall_len cycles when output number stall_at is presented.
    task automatic collect(input int n, input int stall_at, input int stall_len);
        int cyc;
        int got;
        logic [W-1:0] snap;
        cyc      = 0;
        got      = 0;
        held_bad = 0;
        got_q.delete();
        while (got < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (o_valid) begin
                if (got == stall_at && stall_len > 0) begin
                    out_ready = 1'b0;
                    snap = {o_x, o_y, o_index, o_last};
                    for (int s = 0; s < stall_len; s++) begin
                        @(negedge clk);
                        if (!o_valid || ({o_x, o_y, o_index, o_last} != snap)) held_bad++;
                    end
                end
                got_q.push_back({o_x, o_y, o_index, o_last});
                got++;
                out_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic score(input string name);
        logic [W-1:0] e;
        logic [W-1:0] g;
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d outputs, required %0d", name, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s_out: got x=%0d y=%0d idx=%0d last=%b, required x=%0d y=%0d idx=%0d last=%b",
                         name, g[14:10], g[9:5], g[4:1], g[0], e[14:10], e[9:5], e[4:1], e[0]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({o_valid, o_last, o_x, o_y, o_index} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%b x=%0d y=%0d idx=%0d, required all 0",
                     o_valid, o_last, o_x, o_y, o_index);
        end
        n_tests++;
        if (o_total_length !== '0) begin
            n_fail++;
            $display("FAIL reset_length: got %0d, required 0", o_total_length);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (o_ready !== 1'b1 || o_dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got ready=%b state=%0d, required ready=1 state=0", o_ready, o_dbg_state);
        end
    endtask

    task automatic test_line(input int stall_at, input int stall_len, input string name);
        send_line(17);
        collect(16, stall_at, stall_len);
        for (int k = 0; k < 16; k++) exp_q.push_back({5'(k), 5'd0, 4'(k), (k == 15)});
        score(name);
        n_tests++;
        if (o_total_length !== 17'd16) begin
            n_fail++;
            $display("FAIL %s_length: got %0d, required 16", name, o_total_length);
        end
        n_tests++;
        if (o_dbg_state !== 2'd0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: got state=%0d ready=%b, required state=0 ready=1", name, o_dbg_state, o_ready);
        end
        if (stall_len > 0) begin
            n_tests++;
            if (held_bad != 0) begin
                n_fail++;
                $display("FAIL %s_hold: got %0d unstable cycles, required 0", name, held_bad);
            end
        end
    endtask

    task automatic test_degenerate();
        for (int k = 0; k < 3; k++) send_point(5'd7, 5'd7, (k == 2));
        collect(16, -1, 0);
        for (int k = 0; k < 16; k++) exp_q.push_back({5'd7, 5'd7, 4'(k), (k == 15)});
        score("degenerate");
        n_tests++;
        if (o_total_length !== 17'd0 || o_dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL degenerate_end: got len=%0d state=%0d, required len=0 state=0", o_total_length, o_dbg_state);
        end
    endtask

    task automatic test_long_segment();
        send_point(5'd0, 5'd0, 1'b0);
        send_point(5'd4, 5'd0, 1'b1);
        collect(16, -1, 0);
        exp_q.push_back({5'd0, 5'd0, 4'd0, 1'b0});
        for (int k = 1; k < 16; k++) exp_q.push_back({5'd4, 5'd0, 4'(k), (k == 15)});
        score("long_segment");
        n_tests++;
        if (o_total_length !== 17'd16) begin
            n_fail++;
            $display("FAIL long_segment_length: got %0d, required 16", o_total_length);
        end
    endtask

    task automatic test_full_buffer();
        int meas;
        // x = k>>1 gives 31 unit segments among 63: L=31, S=1, output k at x=k.
        for (int k = 0; k < 64; k++) send_point(5'(k >> 1), 5'd0, 1'b0);
        n_tests++;
        if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b after 64th transfer, required 0", o_ready);
        end
        meas = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_dbg_state != 2'd2) break;
            meas++;
        end
        n_tests++;
        if (meas != 63) begin
            n_fail++;
            $display("FAIL full_measure: got %0d cycles, required 63", meas);
        end
        collect(16, -1, 0);
        for (int k = 0; k < 16; k++) exp_q.push_back({5'(k), 5'd0, 4'(k), (k == 15)});
        score("full_buffer");
        n_tests++;
        if (o_total_length !== 17'd31) begin
            n_fail++;
            $display("FAIL full_length: got %0d, required 31", o_total_length);
        end
    endtask

    task automatic test_reset_mid_emit();
        send_line(17);
        collect(5, -1, 0);
        for (int k = 0; k < 5; k++) exp_q.push_back({5'(k), 5'd0, 4'(k), 1'b0});
        score("pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b ready=%b, required valid=0 ready=1", o_valid, o_ready);
        end
        rst_n = 1'b1;
        test_line(-1, 0, "after_reset");
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        test_reset();
        test_line(-1, 0, "line");
        test_degenerate();
        test_long_segment();
        test_line(5, 3, "backpressure");
        test_full_buffer();
        test_reset_mid_emit();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
